// File: rtl/geriyaz_hakem.sv
// Round-robin arbiter for the single register-file writeback port, with a registered
// write interface and a saturating contention counter.
module geriyaz_hakem #(
    parameter int KAYNAK_SAYISI = 4,
    parameter int VERI_BIT      = 32,
    parameter int YAZMAC_BIT    = 5,
    parameter int ETIKET_BIT    = 4,
    parameter int SAYAC_BIT     = 16
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic [KAYNAK_SAYISI-1:0]            istek_gecerli_i,
    input  logic [KAYNAK_SAYISI*VERI_BIT-1:0]   istek_veri_i,
    input  logic [KAYNAK_SAYISI*YAZMAC_BIT-1:0] istek_adres_i,
    input  logic [KAYNAK_SAYISI*ETIKET_BIT-1:0] istek_etiket_i,
    output logic [KAYNAK_SAYISI-1:0]            istek_hazir_o,
    output logic [VERI_BIT-1:0]                 geriyaz_veri_o,
    output logic [YAZMAC_BIT-1:0]               geriyaz_adres_o,
    output logic [ETIKET_BIT-1:0]               geriyaz_etiket_o,
    output logic                                geriyaz_gecerli_o,
    input  logic                                sayac_temizle_i,
    output logic [SAYAC_BIT-1:0]                cakisma_sayac_o
);
    localparam int N  = KAYNAK_SAYISI;
    localparam int PW = $clog2(N);
    localparam int YW = VERI_BIT + YAZMAC_BIT + ETIKET_BIT;

    typedef struct packed {
        logic [VERI_BIT-1:0]   veri;
        logic [YAZMAC_BIT-1:0] adres;
        logic [ETIKET_BIT-1:0] etiket;
    } istek_t;

    istek_t [N-1:0]         istek;
    logic   [N-1:0][YW-1:0] maskeli;
    logic   [N-1:0]         hazir;
    logic   [YW-1:0]        secilen;
    istek_t                 sec_istek;
    logic   [PW-1:0]        son_r;
    logic   [PW-1:0]        kazanan;
    logic   [PW-1:0]        idx_k;
    logic                   aktarim;
    logic   [3:0]           gecerli_sayi;
    logic                   cakisma;

    // Grant is one-hot, so the winning slice is an AND-OR of masked lanes.
    for (genvar g = 0; g < N; g++) begin : g_serit
        assign istek[g]   = '{veri:   istek_veri_i[g*VERI_BIT +: VERI_BIT],
                              adres:  istek_adres_i[g*YAZMAC_BIT +: YAZMAC_BIT],
                              etiket: istek_etiket_i[g*ETIKET_BIT +: ETIKET_BIT]};
        assign maskeli[g] = {YW{hazir[g]}} & istek[g];
    end

    always_comb begin
        secilen = '0;
        for (int i = 0; i < N; i++) secilen = secilen | maskeli[i];
    end
    assign sec_istek = istek_t'(secilen);

    // Search starts just after the last winner; wrap by compare since N may not be 2^k.
    always_comb begin
        int idx;
        idx     = 0;
        idx_k   = '0;
        hazir   = '0;
        kazanan = '0;
        aktarim = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(son_r) + k;
            if (idx >= N) idx = idx - N;
            idx_k = PW'(idx);
            if (!aktarim && istek_gecerli_i[idx_k]) begin
                hazir[idx_k] = 1'b1;
                kazanan      = idx_k;
                aktarim      = 1'b1;
            end
        end
    end
    assign istek_hazir_o = hazir;

    always_comb begin
        gecerli_sayi = '0;
        for (int i = 0; i < N; i++)
            if (istek_gecerli_i[i]) gecerli_sayi = gecerli_sayi + 4'd1;
    end
    assign cakisma = (gecerli_sayi >= 4'd2);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            son_r             <= PW'(N - 1);
            geriyaz_veri_o    <= '0;
            geriyaz_adres_o   <= '0;
            geriyaz_etiket_o  <= '0;
            geriyaz_gecerli_o <= 1'b0;
            cakisma_sayac_o   <= '0;
        end else begin
            // x0 writes are consumed but never strobe the register file.
            geriyaz_gecerli_o <= aktarim && (sec_istek.adres != '0);
            if (aktarim) begin
                son_r            <= kazanan;
                geriyaz_veri_o   <= sec_istek.veri;
                geriyaz_adres_o  <= sec_istek.adres;
                geriyaz_etiket_o <= sec_istek.etiket;
            end
            if (sayac_temizle_i)
                cakisma_sayac_o <= '0;
            else if (cakisma && (cakisma_sayac_o != '1))
                cakisma_sayac_o <= cakisma_sayac_o + SAYAC_BIT'(1);
        end
    end
endmodule

// File: tb/tb_geriyaz_hakem.sv
// Directed table, hand-written corner sequences and a random hold-protocol scoreboard
// for the writeback arbiter (N=4 main instance, N=3 second instance).
module tb_geriyaz_hakem;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [3:0]   gec4;
    logic [127:0] veri4;
    logic [19:0]  adres4;
    logic [15:0]  etiket4;
    logic [3:0]   hz4;
    logic [31:0]  wveri4;
    logic [4:0]   wadres4;
    logic [3:0]   wetiket4;
    logic         wgec4;
    logic         tem4;
    logic [15:0]  say4;

    logic [2:0]   gec3;
    logic [95:0]  veri3;
    logic [14:0]  adres3;
    logic [11:0]  etiket3;
    logic [2:0]   hz3;
    logic [31:0]  wveri3;
    logic [4:0]   wadres3;
    logic [3:0]   wetiket3;
    logic         wgec3;
    logic         tem3;
    logic [15:0]  say3;

    geriyaz_hakem #(.KAYNAK_SAYISI(4)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .istek_gecerli_i(gec4), .istek_veri_i(veri4), .istek_adres_i(adres4),
        .istek_etiket_i(etiket4), .istek_hazir_o(hz4),
        .geriyaz_veri_o(wveri4), .geriyaz_adres_o(wadres4), .geriyaz_etiket_o(wetiket4),
        .geriyaz_gecerli_o(wgec4), .sayac_temizle_i(tem4), .cakisma_sayac_o(say4));

    geriyaz_hakem #(.KAYNAK_SAYISI(3)) dut3 (
        .clk_i(clk), .rstn_i(rstn),
        .istek_gecerli_i(gec3), .istek_veri_i(veri3), .istek_adres_i(adres3),
        .istek_etiket_i(etiket3), .istek_hazir_o(hz3),
        .geriyaz_veri_o(wveri3), .geriyaz_adres_o(wadres3), .geriyaz_etiket_o(wetiket3),
        .geriyaz_gecerli_o(wgec3), .sayac_temizle_i(tem3), .cakisma_sayac_o(say3));

    int kontrol = 0;
    int hata    = 0;

    task automatic chk(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        kontrol++;
        if (gercek !== beklenen) begin
            hata++;
            $display("FAIL %s: got %0h expected %0h", ad, gercek, beklenen);
        end
    endtask

    task automatic serit4(input int i, input logic [31:0] v, input logic [4:0] a, input logic [3:0] e);
        veri4[i*32 +: 32]  = v;
        adres4[i*5 +: 5]   = a;
        etiket4[i*4 +: 4]  = e;
    endtask

    task automatic sifirla();
        rstn = 1'b0;
        gec4 = '0; gec3 = '0; tem4 = 1'b0; tem3 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    function automatic logic [31:0] tab_veri(input int i, input logic [4:0] a);
        return 32'hA000_0000 | (32'(i) << 8) | 32'(a);
    endfunction

    typedef struct {
        logic [3:0]      gec;
        logic [3:0][4:0] adr;
        logic [3:0]      hz;
        logic            wb;
        logic [4:0]      adr_o;
        logic [15:0]     say;
    } vek_t;
    vek_t tab[10];

    // Random-phase scoreboard state, [dut][lane]; dut 0 is N=4, dut 1 is N=3.
    logic        act[2][4];
    logic [31:0] rv[2][4];
    logic [4:0]  ra[2][4];
    logic [3:0]  rt[2][4];
    int          bek[2][4];
    logic        pv[2];
    logic [31:0] pveri[2];
    logic [4:0]  padres[2];
    logic [3:0]  petiket[2];

    initial begin
        logic [31:0] mv;
        logic [3:0]  me;
        logic [3:0]  hz, gv;
        int          n, tagc;

        tab[0] = '{4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0001, 1'b1, 5'd1, 16'd1};
        tab[1] = '{4'b1110, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0010, 1'b1, 5'd2, 16'd2};
        tab[2] = '{4'b1100, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0100, 1'b1, 5'd3, 16'd3};
        tab[3] = '{4'b1000, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1000, 1'b1, 5'd4, 16'd3};
        tab[4] = '{4'b0000, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 1'b0, 5'd4, 16'd3};
        tab[5] = '{4'b0010, {5'd4, 5'd3, 5'd0, 5'd1}, 4'b0010, 1'b0, 5'd0, 16'd3};
        tab[6] = '{4'b0110, {5'd4, 5'd9, 5'd7, 5'd1}, 4'b0100, 1'b1, 5'd9, 16'd4};
        tab[7] = '{4'b0010, {5'd4, 5'd9, 5'd7, 5'd1}, 4'b0010, 1'b1, 5'd7, 16'd4};
        tab[8] = '{4'b1001, {5'd4, 5'd9, 5'd7, 5'd1}, 4'b1000, 1'b1, 5'd4, 16'd5};
        tab[9] = '{4'b0001, {5'd4, 5'd9, 5'd7, 5'd1}, 4'b0001, 1'b1, 5'd1, 16'd5};

        veri4 = '0; adres4 = '0; etiket4 = '0;
        veri3 = '0; adres3 = '0; etiket3 = '0;
        sifirla();

        // Reset state and a single lone requester.
        chk("rst_wgec", 64'(wgec4), 64'd0);
        chk("rst_wveri", 64'(wveri4), 64'd0);
        chk("rst_wadres", 64'(wadres4), 64'd0);
        chk("rst_say", 64'(say4), 64'd0);
        chk("rst_hz_idle", 64'(hz4), 64'd0);
        serit4(2, 32'hDEADBEEF, 5'd5, 4'd3);
        gec4 = 4'b0100;
        #1 chk("t1_hz", 64'(hz4), 64'b0100);
        @(posedge clk); #1;
        chk("t1_wgec", 64'(wgec4), 64'd1);
        chk("t1_wveri", 64'(wveri4), 64'hDEADBEEF);
        chk("t1_wadres", 64'(wadres4), 64'd5);
        chk("t1_wetiket", 64'(wetiket4), 64'd3);
        gec4 = '0;

        // Table: full contention round, x0 write, pointer-driven ordering.
        sifirla();
        mv = '0; me = '0;
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 4; i++) serit4(i, tab_veri(i, tab[v].adr[i]), tab[v].adr[i], 4'(i));
            gec4 = tab[v].gec;
            #1 chk($sformatf("tab%0d_hz", v), 64'(hz4), 64'(tab[v].hz));
            for (int i = 0; i < 4; i++)
                if (tab[v].hz[i]) begin
                    mv = tab_veri(i, tab[v].adr[i]);
                    me = 4'(i);
                end
            @(posedge clk); #1;
            chk($sformatf("tab%0d_wgec", v), 64'(wgec4), 64'(tab[v].wb));
            chk($sformatf("tab%0d_wadres", v), 64'(wadres4), 64'(tab[v].adr_o));
            chk($sformatf("tab%0d_wveri", v), 64'(wveri4), 64'(mv));
            chk($sformatf("tab%0d_wetiket", v), 64'(wetiket4), 64'(me));
            chk($sformatf("tab%0d_say", v), 64'(say4), 64'(tab[v].say));
        end

        // Counter: clear wins over contention, then run up to saturation.
        gec4 = 4'b0011; tem4 = 1'b1;
        #1 chk("t4_hz_clr", 64'(hz4), 64'b0010);
        @(posedge clk); #1;
        chk("t4_clr", 64'(say4), 64'd0);
        tem4 = 1'b0;
        for (int k = 0; k < 65534; k++) begin
            chk("t4_alt_hz", 64'(hz4), (k % 2 == 0) ? 64'b0001 : 64'b0010);
            @(posedge clk); #1;
        end
        chk("t4_fffe", 64'(say4), 64'hFFFE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("t4_sat", 64'(say4), 64'hFFFF);
        end
        tem4 = 1'b1;
        @(posedge clk); #1;
        chk("t4_clr_sat", 64'(say4), 64'd0);
        tem4 = 1'b0;
        @(posedge clk); #1;
        chk("t4_one", 64'(say4), 64'd1);

        // Asynchronous reset right after a grant discards the pending strobe.
        serit4(0, 32'h1111_0000, 5'd6, 4'd9);
        serit4(3, 32'h3333_0000, 5'd7, 4'd10);
        gec4 = 4'b0001;
        #1 chk("t5_hz", 64'(hz4), 64'b0001);
        @(posedge clk); #1;
        chk("t5_wgec_pre", 64'(wgec4), 64'd1);
        #1 rstn = 1'b0;
        #1;
        chk("t5_wgec_rst", 64'(wgec4), 64'd0);
        chk("t5_wadres_rst", 64'(wadres4), 64'd0);
        chk("t5_say_rst", 64'(say4), 64'd0);
        gec4 = 4'b1001;
        #1 chk("t5_hz_rst", 64'(hz4), 64'b0001);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("t5_wadres0", 64'(wadres4), 64'd6);
        chk("t5_wgec0", 64'(wgec4), 64'd1);
        chk("t5_say", 64'(say4), 64'd1);
        gec4 = 4'b1000;
        #1 chk("t5_hz3", 64'(hz4), 64'b1000);
        @(posedge clk); #1;
        chk("t5_wadres3", 64'(wadres4), 64'd7);
        chk("t5_wetiket3", 64'(wetiket4), 64'd10);

        // Random requesters obeying the hold protocol on both instances.
        sifirla();
        tagc = 0;
        for (int d = 0; d < 2; d++) begin
            pv[d] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                act[d][i] = 1'b0; bek[d][i] = 0;
                rv[d][i] = '0; ra[d][i] = '0; rt[d][i] = '0;
            end
        end
        for (int c = 0; c < 4000; c++) begin
            for (int d = 0; d < 2; d++) begin
                n = (d == 0) ? 4 : 3;
                if (pv[d]) begin
                    chk("rnd_wgec", 64'((d == 0) ? wgec4 : wgec3), 64'(padres[d] != 5'd0));
                    chk("rnd_wveri", 64'((d == 0) ? wveri4 : wveri3), 64'(pveri[d]));
                    chk("rnd_wadres", 64'((d == 0) ? wadres4 : wadres3), 64'(padres[d]));
                    chk("rnd_wetiket", 64'((d == 0) ? wetiket4 : wetiket3), 64'(petiket[d]));
                end else begin
                    chk("rnd_idle_wgec", 64'((d == 0) ? wgec4 : wgec3), 64'd0);
                end
                for (int i = 0; i < n; i++)
                    if (!act[d][i] && $urandom_range(0, 2) == 0) begin
                        act[d][i] = 1'b1;
                        rv[d][i]  = $urandom;
                        ra[d][i]  = 5'($urandom_range(0, 31));
                        rt[d][i]  = 4'(tagc);
                        bek[d][i] = 0;
                        tagc++;
                    end
            end
            for (int i = 0; i < 4; i++) begin
                gec4[i] = act[0][i];
                serit4(i, rv[0][i], ra[0][i], rt[0][i]);
            end
            for (int i = 0; i < 3; i++) begin
                gec3[i] = act[1][i];
                veri3[i*32 +: 32] = rv[1][i];
                adres3[i*5 +: 5]  = ra[1][i];
                etiket3[i*4 +: 4] = rt[1][i];
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                n  = (d == 0) ? 4 : 3;
                hz = (d == 0) ? hz4 : {1'b0, hz3};
                gv = (d == 0) ? gec4 : {1'b0, gec3};
                chk("rnd_subset", 64'(hz & ~gv), 64'd0);
                chk("rnd_onehot", 64'($onehot0(hz)), 64'd1);
                chk("rnd_served", 64'(hz != 4'd0), 64'(gv != 4'd0));
                pv[d] = 1'b0;
                for (int i = 0; i < n; i++) begin
                    if (hz[i]) begin
                        pv[d]      = 1'b1;
                        pveri[d]   = rv[d][i];
                        padres[d]  = ra[d][i];
                        petiket[d] = rt[d][i];
                        act[d][i]  = 1'b0;
                        bek[d][i]  = 0;
                    end else if (act[d][i]) begin
                        bek[d][i]++;
                        chk("rnd_wait", 64'(bek[d][i] > n - 1), 64'd0);
                    end
                end
            end
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", kontrol, hata);
        $finish;
    end
endmodule
